// File: rtl/noc_word_packer.sv
// Packs a stream of narrow words with end-of-packet marks into 128-bit NOC beats
// with byte lengths, buffered through a 2-entry output FIFO.
module noc_word_packer #(
  parameter int IN_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_enq__ENA,
  input  logic [IN_WIDTH-1:0] in_enq_v,
  input  logic                in_enq_last,
  output logic                in_enq__RDY,
  input  logic                out_deq__ENA,
  output logic                out_deq__RDY,
  output logic [143:0]        out_first,
  output logic                out_first__RDY,
  output logic                out_last,
  output logic                out_last__RDY
);

  localparam int BEATS = 128 / IN_WIDTH;
  localparam int BYTES = IN_WIDTH / 8;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  length;
    logic         last;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

  logic [2:0]   cnt_q, cnt_d;
  logic [127:0] acc_q, acc_d;
  entry_t       s0_q, s0_d;
  entry_t       s1_q, s1_d;
  occ_e         occ_q, occ_d;

  logic         enq_rdy, deq_rdy;
  logic         fire, pop, complete;
  logic [127:0] merged;
  logic [15:0]  len_w;
  entry_t       new_e;

  assign enq_rdy  = !RST && (occ_q != OCC_FULL);
  assign deq_rdy  = !RST && (occ_q != OCC_EMPTY);
  assign fire     = in_enq__ENA && enq_rdy;
  assign pop      = out_deq__ENA && deq_rdy;
  assign complete = fire && (in_enq_last || (cnt_q == 3'(BEATS - 1)));
  assign len_w    = (16'(cnt_q) + 16'd1) * 16'(BYTES);

  always_comb begin
    merged = acc_q;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (3'(i) == cnt_q) merged[i*IN_WIDTH +: IN_WIDTH] = in_enq_v;
    end
  end

  always_comb begin
    new_e.data   = merged;
    new_e.length = len_w;
    new_e.last   = in_enq_last;
  end

  // A completing word clears the accumulator so unfilled slots of the next short beat read as zero.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (fire) begin
      if (complete) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
        acc_d = merged;
      end
    end
  end

  // s0 is always the head; push-with-pop at one entry writes the new beat straight into s0.
  always_comb begin
    s0_d  = s0_q;
    s1_d  = s1_q;
    occ_d = occ_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (complete) begin
          s0_d  = new_e;
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (complete && pop) begin
          s0_d = new_e;
        end else if (complete) begin
          s1_d  = new_e;
          occ_d = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          s0_d  = s1_q;
          occ_d = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      acc_q <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      occ_q <= OCC_EMPTY;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      occ_q <= occ_d;
    end
  end

  assign in_enq__RDY    = enq_rdy;
  assign out_deq__RDY   = deq_rdy;
  assign out_first__RDY = deq_rdy;
  assign out_last__RDY  = deq_rdy;
  assign out_first      = deq_rdy ? {s0_q.data, s0_q.length} : '0;
  assign out_last       = deq_rdy && s0_q.last;

endmodule

// File: tb/tb_noc_word_packer.sv
// Randomised and directed checks of noc_word_packer (IN_WIDTH=32) against a
// queue-based model of packets chopped into beats of up to four words.
module tb_noc_word_packer;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ena = 1'b0;
  logic [31:0]  v = '0;
  logic         lst = 1'b0;
  logic         deq = 1'b0;
  logic         in_enq__RDY, out_deq__RDY, out_first__RDY, out_last__RDY, out_last;
  logic [143:0] out_first;

  int n_cmp = 0;
  int n_fail = 0;

  noc_word_packer #(.IN_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(ena), .in_enq_v(v), .in_enq_last(lst), .in_enq__RDY(in_enq__RDY),
    .out_deq__ENA(deq), .out_deq__RDY(out_deq__RDY),
    .out_first(out_first), .out_first__RDY(out_first__RDY),
    .out_last(out_last), .out_last__RDY(out_last__RDY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  len;
    logic         last;
  } beat_t;

  beat_t       expq[$];
  logic [31:0] pend[$];
  logic [148:0] obs;

  function automatic logic m_rdy();
    return !RST && (expq.size() != 2);
  endfunction

  function automatic logic m_drdy();
    return !RST && (expq.size() != 0);
  endfunction

  function automatic logic [148:0] exp_vec();
    logic [143:0] f;
    logic         l;
    f = '0;
    l = 1'b0;
    if (m_drdy()) begin
      f = {expq[0].d, expq[0].len};
      l = expq[0].last;
    end
    return {m_rdy(), m_drdy(), m_drdy(), m_drdy(), f, l};
  endfunction

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic tick(input logic e, input logic [31:0] w, input logic l, input logic d);
    beat_t b;
    e = e && m_rdy();
    d = d && m_drdy();
    ena = e; v = w; lst = l; deq = d;
    @(posedge CLK);
    if (RST) begin
      expq.delete();
      pend.delete();
    end else begin
      if (d) void'(expq.pop_front());
      if (e) begin
        pend.push_back(w);
        if (l || pend.size() == 4) begin
          b.d = '0;
          for (int i = 0; i < pend.size(); i++) b.d[32*i +: 32] = pend[i];
          b.len  = 16'(pend.size() * 4);
          b.last = l;
          expq.push_back(b);
          pend.delete();
        end
      end
    end
    @(negedge CLK);
    ena = 1'b0; deq = 1'b0; lst = 1'b0;
  endtask

  function automatic logic [148:0] observed();
    return {in_enq__RDY, out_deq__RDY, out_first__RDY, out_last__RDY, out_first, out_last};
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    obs = observed(); n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_hold got %h want 0", obs); end
    RST = 1'b0;
    #1;
    obs = observed(); n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_idle got %h want %h", obs, exp_vec()); end
    n_cmp++;
    if (in_enq__RDY !== 1'b1 || out_deq__RDY !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy got enq=%b deq=%b want 1 0", in_enq__RDY, out_deq__RDY);
    end
  endtask

  task automatic test_full_beat();
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    for (int k = 0; k < 4; k++) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL full_beat cyc%0d got %h want %h", k, obs, exp_vec()); end
      tick(1, w[k], k == 3, m_drdy());
    end
    n_cmp++;
    if (out_deq__RDY !== 1'b1 || out_last !== 1'b1 ||
        out_first !== {128'h00000044_00000033_00000022_00000011, 16'd16}) begin
      n_fail++; $display("FAIL full_beat_data got rdy=%b last=%b first=%h", out_deq__RDY, out_last, out_first);
    end
    tick(0, 0, 0, 1);
    obs = observed(); n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL full_beat_pop got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_short();
    tick(1, 32'hAAAAAAAA, 0, 0);
    obs = observed(); n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL short_mid got %h want %h", obs, exp_vec()); end
    tick(1, 32'hBBBBBBBB, 1, 0);
    n_cmp++;
    if (out_first !== {64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA, 16'd8} || out_last !== 1'b1) begin
      n_fail++; $display("FAIL short_data got first=%h last=%b", out_first, out_last);
    end
    tick(0, 0, 0, 1);
    obs = observed(); n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL short_pop got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_six();
    for (int k = 0; k < 6; k++) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL six cyc%0d got %h want %h", k, obs, exp_vec()); end
      tick(1, $urandom, k == 5, 0);
    end
    n_cmp++;
    if (out_first[15:0] !== 16'd16 || out_last !== 1'b0 || in_enq__RDY !== 1'b0) begin
      n_fail++; $display("FAIL six_beat1 got len=%0d last=%b rdy=%b want 16 0 0", out_first[15:0], out_last, in_enq__RDY);
    end
    obs = observed(); n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL six_beat1_vec got %h want %h", obs, exp_vec()); end
    tick(0, 0, 0, 1);
    n_cmp++;
    if (out_first[15:0] !== 16'd8 || out_last !== 1'b1 || out_first[143:80] !== 64'h0) begin
      n_fail++; $display("FAIL six_beat2 got len=%0d last=%b first=%h want 8 1", out_first[15:0], out_last, out_first);
    end
    obs = observed(); n_cmp++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL six_beat2_vec got %h want %h", obs, exp_vec()); end
    tick(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    int  acc = 0;
    int  cyc = 0;
    bit  popped = 0;
    while (acc < 12 && cyc < 40) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL bp cyc%0d got %h want %h", cyc, obs, exp_vec()); end
      if (acc == 8 && !popped) begin
        tick(1, $urandom, 0, 0);
        n_cmp++;
        if (in_enq__RDY !== 1'b0 || out_deq__RDY !== 1'b1) begin
          n_fail++; $display("FAIL bp_full got enq=%b deq=%b want 0 1", in_enq__RDY, out_deq__RDY);
        end
        tick(0, 0, 0, 1);
        n_cmp++;
        if (in_enq__RDY !== 1'b1) begin n_fail++; $display("FAIL bp_release got enq=%b want 1", in_enq__RDY); end
        popped = 1;
      end else begin
        if (m_rdy()) acc++;
        tick(1, $urandom, 0, 0);
      end
      cyc++;
    end
    n_cmp++;
    if (acc != 12) begin n_fail++; $display("FAIL bp_timeout got %0d words want 12", acc); end
    for (int k = 0; k < 3; k++) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL bp_drain%0d got %h want %h", k, obs, exp_vec()); end
      tick(0, 0, 0, 1);
    end
  endtask

  task automatic test_throughput();
    int pops = 0;
    int lasts = 0;
    int cyc = 0;
    bit final_last = 0;
    for (int k = 0; k < 16; k++) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec() || in_enq__RDY !== 1'b1) begin
        n_fail++; $display("FAIL tput cyc%0d got %h want %h", k, obs, exp_vec());
      end
      if (out_deq__RDY === 1'b1) begin pops++; if (out_last === 1'b1) lasts++; end
      tick(1, $urandom, k == 15, out_deq__RDY === 1'b1);
    end
    while (out_deq__RDY === 1'b1 && cyc < 8) begin
      pops++;
      if (out_last === 1'b1) begin lasts++; final_last = (pops == 4); end
      tick(0, 0, 0, 1);
      cyc++;
    end
    n_cmp++;
    if (pops != 4 || lasts != 1 || !final_last) begin
      n_fail++; $display("FAIL tput_beats got pops=%0d lasts=%0d final=%0d want 4 1 1", pops, lasts, final_last);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w [4];
    tick(1, 32'hDEAD0001, 0, 0);
    tick(1, 32'hDEAD0002, 0, 0);
    RST = 1'b1;
    #1;
    n_cmp++;
    if (in_enq__RDY !== 1'b0 || out_deq__RDY !== 1'b0 || out_first !== '0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold got enq=%b deq=%b first=%h", in_enq__RDY, out_deq__RDY, out_first);
    end
    @(negedge CLK);
    tick(0, 0, 0, 0);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w[k] = $urandom;
      tick(1, w[k], k == 3, 0);
    end
    n_cmp++;
    if (out_first !== {w[3], w[2], w[1], w[0], 16'd16} || out_last !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_data got first=%h last=%b", out_first, out_last);
    end
    tick(0, 0, 0, 1);
    obs = observed(); n_cmp++;
    if (obs !== exp_vec() || out_deq__RDY !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_single got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand cyc%0d got %h want %h", c, obs, exp_vec()); end
      tick($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);
    end
    for (int c = 0; c < 4; c++) begin
      obs = observed(); n_cmp++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rand_drain%0d got %h want %h", c, obs, exp_vec()); end
      tick(0, 0, 0, 1);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_full_beat();
    test_short();
    test_six();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
